cpu_divider_ctrl: RTL

//  Initiator side of the multi-cycle divider: accepts DIV/DIVU/REM/REMU requests from the
//  CPU execute stage, strips signs, pulses the divider start, holds operands stable, waits
//  for done, fixes up sign/divide-by-zero and returns one 32-bit result with valid/ready.

---
 rtl/cpu_divider_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_divider_ctrl.sv
// cpu_divider_ctrl: initiator side of the multi-cycle divider.
// Takes DIVU/DIV/REMU/REM requests, strips operand signs, launches the divider,
// applies divide-by-zero fix-up and returns one 32-bit result over valid/ready.
// Optional feature macro: DIV_CACHE_EN -- remembers the last completed division
// (quotient and remainder) and answers a repeated {a, b, signedness} directly.
module cpu_divider_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 34
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_op,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   input  logic        resp_ready,
   output logic        div_start,
   output logic [31:0] div_numerator,
   output logic [31:0] div_denominator,
   output logic        div_sign,
   input  logic [31:0] div_quotient,
   input  logic [31:0] div_remainder,
   input  logic        div_done
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   typedef enum logic [2:0] {
      S_FLUSH,
      S_IDLE,
      S_START,
      S_WAIT,
      S_RESP
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  flush_cnt;

   // Context of the accepted request, needed when the result comes back
   logic              op_rem;
   logic [DATA_W-1:0] a_orig;
   logic              b_zero;

   // Request-side operand conditioning
   logic              req_signed;
   logic              req_rem;
   logic [DATA_W-1:0] req_a_mag;
   logic [DATA_W-1:0] req_b_mag;
   logic              req_sign;

   // Result fix-up at divider completion
   logic [DATA_W-1:0] fix_quo;
   logic [DATA_W-1:0] fix_rem;
   logic [DATA_W-1:0] fix_result;

`ifdef DIV_CACHE_EN
   logic              op_signed;
   logic              b_neg;
   logic              cache_valid;
   logic [DATA_W-1:0] cache_a;
   logic [DATA_W-1:0] cache_b;
   logic              cache_signed;
   logic [DATA_W-1:0] cache_quo;
   logic [DATA_W-1:0] cache_rem;
   logic              cache_hit;

   // Repeat of the last completed division with the same signedness
   assign cache_hit = cache_valid
                      && (cache_a == req_a)
                      && (cache_b == req_b)
                      && (cache_signed == req_signed);
`endif

   // Strip signs for signed ops and pick the sign the divider applies to its results
   always_comb begin
      req_signed = req_op[0];
      req_rem    = req_op[1];
      req_a_mag  = req_a;
      req_b_mag  = req_b;
      req_sign   = 1'b0;
      if (req_signed) begin
         if (req_a[DATA_W-1]) begin
            req_a_mag = -req_a;
         end
         if (req_b[DATA_W-1]) begin
            req_b_mag = -req_b;
         end
         req_sign = req_rem ? req_a[DATA_W-1] : (req_a[DATA_W-1] ^ req_b[DATA_W-1]);
      end
   end

   // Divide-by-zero override and result selection
   always_comb begin
      fix_quo = div_quotient;
      fix_rem = div_remainder;
`ifdef DIV_CACHE_EN
      // The divider signs both results with div_sign; the one not requested
      // carries the wrong sign exactly when the divisor was negative.
      if (op_signed && b_neg) begin
         if (op_rem) begin
            fix_quo = -div_quotient;
         end else begin
            fix_rem = -div_remainder;
         end
      end
`endif
      if (b_zero) begin
         fix_quo = '1;
         fix_rem = a_orig;
      end
      fix_result = op_rem ? fix_rem : fix_quo;
   end

   // Control FSM with registered handshake, divider interface and result
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_FLUSH;
         flush_cnt       <= FLUSH_LOAD;
         req_ready       <= 1'b0;
         resp_valid      <= 1'b0;
         resp_data       <= '0;
         div_start       <= 1'b0;
         div_numerator   <= '0;
         div_denominator <= '0;
         div_sign        <= 1'b0;
         op_rem          <= 1'b0;
         a_orig          <= '0;
         b_zero          <= 1'b0;
`ifdef DIV_CACHE_EN
         op_signed       <= 1'b0;
         b_neg           <= 1'b0;
         cache_valid     <= 1'b0;
         cache_a         <= '0;
         cache_b         <= '0;
         cache_signed    <= 1'b0;
         cache_quo       <= '0;
         cache_rem       <= '0;
`endif
      end else begin
         div_start <= 1'b0;
         case (state)
            // Hold off requests so an orphaned division can finish; div_done ignored
            S_FLUSH: begin
               if (flush_cnt == '0) begin
                  state     <= S_IDLE;
                  req_ready <= 1'b1;
               end else begin
                  flush_cnt <= flush_cnt - CNT_W'(1);
               end
            end

            S_IDLE: begin
               if (req_valid && req_ready) begin
                  req_ready       <= 1'b0;
                  op_rem          <= req_rem;
                  a_orig          <= req_a;
                  b_zero          <= (req_b == '0);
                  div_numerator   <= req_a_mag;
                  div_denominator <= req_b_mag;
                  div_sign        <= req_sign;
`ifdef DIV_CACHE_EN
                  op_signed       <= req_signed;
                  b_neg           <= req_signed & req_b[DATA_W-1];
                  if (cache_hit) begin
                     state      <= S_RESP;
                     resp_valid <= 1'b1;
                     resp_data  <= req_rem ? cache_rem : cache_quo;
                  end else begin
                     state        <= S_START;
                     div_start    <= 1'b1;
                     cache_valid  <= 1'b0;
                     cache_a      <= req_a;
                     cache_b      <= req_b;
                     cache_signed <= req_signed;
                  end
`else
                  state     <= S_START;
                  div_start <= 1'b1;
`endif
               end
            end

            // div_start is high for this single cycle
            S_START: begin
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (div_done) begin
                  state      <= S_RESP;
                  resp_valid <= 1'b1;
                  resp_data  <= fix_result;
`ifdef DIV_CACHE_EN
                  cache_valid <= 1'b1;
                  cache_quo   <= fix_quo;
                  cache_rem   <= fix_rem;
`endif
               end
            end

            S_RESP: begin
               if (resp_ready) begin
                  state      <= S_IDLE;
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
               end
            end

            default: begin
               state      <= S_FLUSH;
               flush_cnt  <= FLUSH_LOAD;
               req_ready  <= 1'b0;
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
